// File: rtl/hi_lo_mac_unit.sv
// HI/LO multiply-accumulate unit: iterative shift-add mult/multu/madd/msub plus single-cycle mthi/mtlo.
// Optional EARLY_TERM_EN: leave MUL as soon as the remaining multiplier bits are all zero.
module hi_lo_mac_unit #(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [4:0]  Op,
    input  logic        Signed,
    input  logic        Flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int N  = 32 / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    localparam logic [4:0] OP_MULT = 5'b00010;
    localparam logic [4:0] OP_MADD = 5'b10100;
    localparam logic [4:0] OP_MSUB = 5'b10101;
    localparam logic [4:0] OP_MTHI = 5'b01111;
    localparam logic [4:0] OP_MTLO = 5'b10000;

    typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

    state_t          state;
    logic [63:0]     a_sh;
    logic [31:0]     b_sh;
    logic [63:0]     acc;
    logic            neg;
    logic [4:0]      op_r;
    logic [CW-1:0]   cnt;

    logic [63:0]     pp;
    logic [31:0]     b_next;
    logic            mul_last;
    logic            is_mul_op;
    logic [31:0]     a_abs;
    logic [31:0]     b_abs;
    logic [63:0]     prod;
    logic [63:0]     wb_val;

    assign is_mul_op = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB);
    assign a_abs     = (Signed && A[31]) ? -A : A;
    assign b_abs     = (Signed && B[31]) ? -B : B;
    assign b_next    = b_sh >> BITS_PER_CYCLE;

    // Partial product of the low multiplier bits against the pre-shifted multiplicand
    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            if (b_sh[i]) pp = pp + (a_sh << i);
    end

`ifdef EARLY_TERM_EN
    assign mul_last = (b_next == '0) || (cnt == CW'(N - 1));
`else
    assign mul_last = (cnt == CW'(N - 1));
`endif

    assign prod = neg ? -acc : acc;

    always_comb begin
        case (op_r)
            OP_MADD: wb_val = {HI, LO} + prod;
            OP_MSUB: wb_val = {HI, LO} - prod;
            default: wb_val = prod;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            HI    <= '0;
            LO    <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            op_r  <= '0;
            cnt   <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    // Start is dropped under Flush and during the Done cycle; the hazard unit holds it
                    if (Start && !Flush && !Done) begin
                        if (is_mul_op) begin
                            a_sh  <= {32'b0, a_abs};
                            b_sh  <= b_abs;
                            neg   <= Signed & (A[31] ^ B[31]);
                            op_r  <= Op;
                            acc   <= '0;
                            cnt   <= '0;
                            Busy  <= 1'b1;
                            state <= MUL;
                        end else if (Op == OP_MTHI) begin
                            HI <= A;
                        end else if (Op == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                MUL: begin
                    if (Flush) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        acc  <= acc + pp;
                        a_sh <= a_sh << BITS_PER_CYCLE;
                        b_sh <= b_next;
                        cnt  <= cnt + 1'b1;
                        if (mul_last) state <= WB;
                    end
                end
                WB: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    if (!Flush) begin
                        {HI, LO} <= wb_val;
                        Done     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hi_lo_mac_unit.sv
// Self-checking bench for hi_lo_mac_unit: directed scenarios plus randomized ops against an arithmetic model.
module tb_hi_lo_mac_unit;
    localparam int BPC = 2;
    localparam int N   = 32 / BPC;

    localparam logic [4:0] OP_MULT = 5'b00010;
    localparam logic [4:0] OP_MADD = 5'b10100;
    localparam logic [4:0] OP_MSUB = 5'b10101;
    localparam logic [4:0] OP_MTHI = 5'b01111;
    localparam logic [4:0] OP_MTLO = 5'b10000;

    logic        Clk = 0;
    logic        Reset = 0, Start = 0, Signed = 0, Flush = 0;
    logic [4:0]  Op = '0;
    logic [31:0] A = '0, B = '0;
    logic        Busy, Done;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;
    logic [63:0] m_hilo = '0;

    hi_lo_mac_unit #(.BITS_PER_CYCLE(BPC)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .Signed(Signed), .Flush(Flush),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    function automatic logic [63:0] model_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'b0, a};
            sb = {32'b0, b};
        end
        return sa * sb;
    endfunction

    function automatic logic [63:0] model_op(input logic [4:0] op, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [63:0] hilo);
        logic [63:0] p;
        p = model_prod(sgn, a, b);
        if (op == OP_MADD) return hilo + p;
        if (op == OP_MSUB) return hilo - p;
        return p;
    endfunction

    // Cycles from the Start edge to Done: iterations + 1
    function automatic int exp_lat(input logic sgn, input logic [31:0] b);
`ifdef EARLY_TERM_EN
        logic [63:0] mag;
        int it;
        mag = {32'b0, (sgn && b[31]) ? -b : b};
        it = 1;
        while (it < N && (mag >> (it * BPC)) != 0) it++;
        return it + 1;
`else
        return N + 1;
`endif
    endfunction

    task automatic run_mul(input logic [4:0] op, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int busy_n, output int done_n);
        @(negedge Clk);
        Op = op; Signed = sgn; A = a; B = b; Start = 1;
        lat = -1; busy_n = 0; done_n = 0;
        @(negedge Clk);
        Start = 0;
        for (int j = 0; j < 60; j++) begin
            if (Busy) busy_n++;
            if (Done) begin
                done_n++;
                if (lat < 0) lat = j;
            end
            @(negedge Clk);
        end
    endtask

    task automatic set_reg(input logic [4:0] op, input logic [31:0] a);
        @(negedge Clk);
        Op = op; A = a; Start = 1;
        @(negedge Clk);
        Start = 0;
        if (op == OP_MTHI) m_hilo[63:32] = a;
        else m_hilo[31:0] = a;
    endtask

    task automatic check_mul(input string name, input logic [4:0] op, input logic sgn,
                             input logic [31:0] a, input logic [31:0] b);
        int lat, busy_n, done_n, el;
        el = exp_lat(sgn, b);
        m_hilo = model_op(op, sgn, a, b, m_hilo);
        run_mul(op, sgn, a, b, lat, busy_n, done_n);
        total++;
        if ({HI, LO} !== m_hilo) begin
            bad++;
            $display("FAIL %s hilo got=%h exp=%h (a=%h b=%h)", name, {HI, LO}, m_hilo, a, b);
        end
        total++;
        if (lat !== el || done_n !== 1) begin
            bad++;
            $display("FAIL %s done got lat=%0d pulses=%0d exp lat=%0d pulses=1", name, lat, done_n, el);
        end
        total++;
        if (busy_n !== el) begin
            bad++;
            $display("FAIL %s busy cycles got=%0d exp=%0d", name, busy_n, el);
        end
    endtask

    task automatic test_reset;
        Reset = 1;
        repeat (2) @(negedge Clk);
        Reset = 0;
        m_hilo = '0;
        total++;
        if (HI !== 0 || LO !== 0 || Busy !== 0 || Done !== 0) begin
            bad++;
            $display("FAIL reset got hi=%h lo=%h busy=%b done=%b exp all 0", HI, LO, Busy, Done);
        end
    endtask

    task automatic test_mult_signed;
        check_mul("mult_neg", OP_MULT, 1, 32'hFFFFFFFD, 32'd7);
        total++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin
            bad++;
            $display("FAIL mult_neg const got=%h_%h exp=ffffffff_ffffffeb", HI, LO);
        end
    endtask

    task automatic test_multu;
        check_mul("multu_max", OP_MULT, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        total++;
        if (HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
            bad++;
            $display("FAIL multu_max const got=%h_%h exp=fffffffe_00000001", HI, LO);
        end
    endtask

    task automatic test_accumulate;
        set_reg(OP_MTLO, 32'd10);
        total++;
        if (LO !== 32'd10 || Busy !== 0 || Done !== 0) begin
            bad++;
            $display("FAIL mtlo got lo=%h busy=%b done=%b exp lo=a busy=0 done=0", LO, Busy, Done);
        end
        set_reg(OP_MTHI, 32'd0);
        check_mul("madd", OP_MADD, 1, 32'd2, 32'hFFFFFFFB);
        total++;
        if (HI !== 0 || LO !== 0) begin
            bad++;
            $display("FAIL madd const got=%h_%h exp=0_0", HI, LO);
        end
        check_mul("msub", OP_MSUB, 1, 32'd1, 32'd1);
        total++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL msub const got=%h_%h exp=ffffffff_ffffffff", HI, LO);
        end
    endtask

    task automatic test_busy_interlock;
        int done_n;
        set_reg(OP_MTHI, 32'h1234);
        @(negedge Clk);
        Op = OP_MULT; Signed = 1; A = 32'd3; B = 32'd5; Start = 1;
        @(negedge Clk);
        Start = 0;
        done_n = 0;
        for (int j = 0; j < 50; j++) begin
            Start = 0;
            if (Done) done_n++;
            // Retry while Busy, and again in the Done cycle: both must be dropped
            if (j == 3 || (Done && done_n == 1)) begin
                Op = OP_MULT; A = 32'd9; B = 32'd9; Start = 1;
            end
            @(negedge Clk);
        end
        Start = 0;
        m_hilo = 64'd15;
        total++;
        if (HI !== 0 || LO !== 32'd15 || done_n !== 1) begin
            bad++;
            $display("FAIL interlock got=%h_%h pulses=%0d exp=0_0000000f pulses=1", HI, LO, done_n);
        end
    endtask

    task automatic test_abort(input bit use_reset);
        int done_n;
        logic bsy;
        set_reg(OP_MTHI, use_reset ? 32'hAAAA : 32'h1111);
        set_reg(OP_MTLO, use_reset ? 32'h5555 : 32'h2222);
        @(negedge Clk);
        Op = OP_MULT; Signed = 1; A = 32'h10000; B = 32'h10000; Start = 1;
        @(negedge Clk);
        Start = 0;
        done_n = 0;
        bsy = 1'b1;
        for (int j = 0; j < 40; j++) begin
            if (Done) done_n++;
            if (j == 6) bsy = Busy;
            if (j == 5) begin
                if (use_reset) Reset = 1; else Flush = 1;
            end else begin
                Reset = 0; Flush = 0;
            end
            @(negedge Clk);
        end
        if (use_reset) m_hilo = '0;
        total++;
        if ({HI, LO} !== m_hilo || bsy !== 0 || done_n !== 0) begin
            bad++;
            $display("FAIL abort_%s got=%h busy=%b pulses=%0d exp=%h busy=0 pulses=0",
                     use_reset ? "reset" : "flush", {HI, LO}, bsy, done_n, m_hilo);
        end
    endtask

    task automatic test_flush_wb;
        int done_n, el;
        el = exp_lat(1, 32'd5);
        @(negedge Clk);
        Op = OP_MULT; Signed = 1; A = 32'd3; B = 32'd5; Start = 1;
        @(negedge Clk);
        Start = 0;
        done_n = 0;
        for (int j = 0; j < 40; j++) begin
            if (Done) done_n++;
            Flush = (j == el - 1);
            @(negedge Clk);
        end
        Flush = 0;
        total++;
        if ({HI, LO} !== m_hilo || done_n !== 0) begin
            bad++;
            $display("FAIL flush_wb got=%h pulses=%0d exp=%h pulses=0", {HI, LO}, done_n, m_hilo);
        end
    endtask

    task automatic test_ignored_start;
        int act;
        @(negedge Clk);
        Op = OP_MTHI; A = 32'hDEAD; Start = 1; Flush = 1;
        @(negedge Clk);
        Start = 0; Flush = 0;
        total++;
        if ({HI, LO} !== m_hilo || Busy !== 0) begin
            bad++;
            $display("FAIL flush_start got=%h busy=%b exp=%h busy=0", {HI, LO}, Busy, m_hilo);
        end
        Op = 5'b00011; A = 32'h77; B = 32'h77; Start = 1;
        act = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge Clk);
            Start = 0;
            if (Busy || Done) act++;
        end
        total++;
        if ({HI, LO} !== m_hilo || act !== 0) begin
            bad++;
            $display("FAIL bad_op got=%h activity=%0d exp=%h activity=0", {HI, LO}, act, m_hilo);
        end
    endtask

    task automatic test_early_term;
        check_mul("mult_small", OP_MULT, 1, 32'd100, 32'd3);
        check_mul("mult_zero_b", OP_MULT, 0, 32'h12345678, 32'd0);
    endtask

    task automatic test_random;
        logic [31:0] edge_v [4] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};
        logic [4:0]  ops [4] = '{OP_MULT, OP_MULT, OP_MADD, OP_MSUB};
        logic [31:0] a, b;
        int k;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom >> $urandom_range(0, 31);
            k = $urandom_range(0, 5);
            if (k >= 4) begin
                set_reg(k == 4 ? OP_MTHI : OP_MTLO, a);
                total++;
                if ({HI, LO} !== m_hilo || Busy !== 0 || Done !== 0) begin
                    bad++;
                    $display("FAIL rand_move got=%h busy=%b done=%b exp=%h", {HI, LO}, Busy, Done, m_hilo);
                end
            end else begin
                check_mul("rand_mul", ops[k], 1'($urandom_range(0, 1)), a, b);
            end
        end
    endtask

    task automatic test_back_to_back;
        check_mul("b2b_0", OP_MULT, 1, 32'h80000000, 32'h80000000);
        check_mul("b2b_1", OP_MADD, 0, 32'hFFFFFFFF, 32'h2);
        check_mul("b2b_2", OP_MSUB, 1, 32'h7FFFFFFF, 32'hFFFFFFFF);
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu();
        test_accumulate();
        test_busy_interlock();
        test_abort(1);
        test_abort(0);
        test_flush_wb();
        test_ignored_start();
        test_early_term();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
